// File: rtl/dmem_result_checker_if.sv
// Data-memory port shared by the CPU and dmem_result_checker.
// The checker drives the strobes, address and write data; data memory returns RD.
interface dmem_result_checker_if;
    logic        MEMRead;
    logic        MEMWrite;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output MEMRead, MEMWrite, ADDR, WD, input RD);
    modport slave  (input MEMRead, MEMWrite, ADDR, WD, output RD);
endinterface

// File: rtl/dmem_result_checker.sv
// Reads back N_WORDS data-memory words after the CPU run and flags each word equal to EXP_BASE+i.
// Define DMEM_CHECK_WRITEBACK_EN to store the pass flag in the word following the window.
module dmem_result_checker #(
    parameter int          N_WORDS   = 10,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] EXP_BASE  = 32'd1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    dmem_result_checker_if.master bus,
    output logic [N_WORDS-1:0]    LED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS
);
    localparam int               IDX_W    = $clog2(N_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

`ifdef DMEM_CHECK_WRITEBACK_EN
    localparam logic [31:0] WB_ADDR = BASE_ADDR + 32'(4 * N_WORDS);
    typedef enum logic [1:0] {IDLE, SCAN, WB, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_WORDS-1:0] led_q, led_d;
    logic               memRead_q, memRead_d;
    logic [31:0]        addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [31:0]        expWord;
    logic               hit;
`ifdef DMEM_CHECK_WRITEBACK_EN
    logic               memWrite_q, memWrite_d;
    logic [31:0]        wd_q, wd_d;
`endif

    always_comb begin
        expWord    = EXP_BASE + 32'(idx_q);
        hit        = 1'b0;
        // An x/z read fails the equality test and leaves hit at 0.
        if (bus.RD == expWord) begin
            hit = 1'b1;
        end

        state_d    = state_q;
        idx_d      = idx_q;
        led_d      = led_q;
        memRead_d  = memRead_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
`ifdef DMEM_CHECK_WRITEBACK_EN
        memWrite_d = memWrite_q;
        wd_d       = wd_q;
`endif

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    led_d     = '0;
                    memRead_d = 1'b1;
                    addr_d    = BASE_ADDR;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            SCAN: begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        led_d[i] = hit;
                    end
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    memRead_d = 1'b0;
`ifdef DMEM_CHECK_WRITEBACK_EN
                    state_d    = WB;
                    memWrite_d = 1'b1;
                    addr_d     = WB_ADDR;
                    wd_d       = {31'b0, &led_d};
`else
                    state_d    = FIN;
                    addr_d     = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = &led_d;
`endif
                end else begin
                    addr_d = BASE_ADDR + (32'(idx_d) << 2);
                end
            end
`ifdef DMEM_CHECK_WRITEBACK_EN
            WB: begin
                state_d    = FIN;
                memWrite_d = 1'b0;
                addr_d     = '0;
                wd_d       = '0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pass_d     = &led_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            led_q      <= '0;
            memRead_q  <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef DMEM_CHECK_WRITEBACK_EN
            memWrite_q <= 1'b0;
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            led_q      <= led_d;
            memRead_q  <= memRead_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef DMEM_CHECK_WRITEBACK_EN
            memWrite_q <= memWrite_d;
            wd_q       <= wd_d;
`endif
        end
    end

    assign bus.MEMRead = memRead_q;
    assign bus.ADDR    = addr_q;
`ifdef DMEM_CHECK_WRITEBACK_EN
    assign bus.MEMWrite = memWrite_q;
    assign bus.WD       = wd_q;
`else
    assign bus.MEMWrite = 1'b0;
    assign bus.WD       = '0;
`endif
    assign LED  = led_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;
endmodule

// File: tb/tb_dmem_result_checker.sv
// Self-checking bench for dmem_result_checker: a word-array memory model plus an
// expected-LED model derived directly from the memory contents.
module tb_dmem_result_checker;
    localparam int          N    = 10;
    localparam logic [31:0] BASE = 32'd0;
    localparam logic [31:0] EXPB = 32'd1;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [N-1:0] LED;
    logic         BUSY;
    logic         DONE;
    logic         PASS;
    int           checks = 0;
    int           errors = 0;

    dmem_result_checker_if bus ();

    dmem_result_checker #(
        .N_WORDS  (N),
        .BASE_ADDR(BASE),
        .EXP_BASE (EXPB)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .bus  (bus),
        .LED  (LED),
        .BUSY (BUSY),
        .DONE (DONE),
        .PASS (PASS)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [0:255];

    assign bus.RD = bus.MEMRead ? mem[bus.ADDR[9:2]] : 'z;

    always @(posedge CLK) begin
        if (bus.MEMWrite) mem[bus.ADDR[9:2]] <= bus.WD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs, then advance to 1 time unit past the next rising edge.
    task automatic applyStimulus(input logic rst, input logic start);
        RST   = rst;
        START = start;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N-1:0] modelLed();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (mem[BASE[9:2] + 8'(i)] === EXPB + 32'(i));
        end
        return r;
    endfunction

    task automatic fillSorted();
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        for (int i = 0; i < N; i++) mem[BASE[9:2] + 8'(i)] = EXPB + 32'(i);
    endtask

    task automatic runScan(input string tag, input bit noisy);
        logic [N-1:0] expLed;
        logic         expPass;
        expLed  = modelLed();
        expPass = &expLed;
        applyStimulus(1'b0, 1'b1);
        START = 1'b0;
        checkOutput({tag, "_cleared"}, {28'b0, BUSY, DONE, PASS, |LED}, 32'b1000);
        for (int k = 0; k < N; k++) begin
            checkOutput({tag, "_addr"}, bus.ADDR, BASE + 32'(4 * k));
            checkOutput({tag, "_scanflags"}, {28'b0, bus.MEMRead, bus.MEMWrite, BUSY, DONE}, 32'b1010);
            applyStimulus(1'b0, noisy ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        START = 1'b0;
`ifdef DMEM_CHECK_WRITEBACK_EN
        checkOutput({tag, "_wbflags"}, {28'b0, bus.MEMRead, bus.MEMWrite, BUSY, DONE}, 32'b0110);
        checkOutput({tag, "_wbaddr"}, bus.ADDR, BASE + 32'(4 * N));
        checkOutput({tag, "_wbdata"}, bus.WD, {31'b0, expPass});
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_wbmem"}, mem[BASE[9:2] + 8'(N)], {31'b0, expPass});
`endif
        checkOutput({tag, "_finflags"}, {28'b0, bus.MEMRead, bus.MEMWrite, BUSY, DONE}, 32'b0001);
        checkOutput({tag, "_finaddr"}, bus.ADDR, 32'd0);
        checkOutput({tag, "_led"}, 32'(LED), 32'(expLed));
        checkOutput({tag, "_pass"}, 32'(PASS), 32'(expPass));
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        fillSorted();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_flags", {27'b0, BUSY, DONE, PASS, bus.MEMRead, bus.MEMWrite}, 32'b0);
        checkOutput("reset_led", 32'(LED), 32'd0);
        checkOutput("reset_addr", bus.ADDR, 32'd0);
        checkOutput("reset_wd", bus.WD, 32'd0);
        applyStimulus(1'b0, 1'b0);

        runScan("sorted", 1'b0);
        checkOutput("sorted_led_const", 32'(LED), 32'h3FF);

        mem[0] = 32'd1; mem[1] = 32'd9; mem[2] = 32'd2; mem[3] = 32'd3; mem[4] = 32'd5;
        mem[5] = 32'd10; mem[6] = 32'd7; mem[7] = 32'd6; mem[8] = 32'd4; mem[9] = 32'd8;
        runScan("unsorted", 1'b0);
        checkOutput("unsorted_led_const", 32'(LED), 32'b0001010001);

        fillSorted();
        applyStimulus(1'b0, 1'b1);
        START = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("abort_in_scan", {30'b0, BUSY, bus.MEMRead}, 32'b11);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_flags", {28'b0, BUSY, DONE, PASS, bus.MEMRead}, 32'b0);
        checkOutput("abort_led", 32'(LED), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_stays_idle", {30'b0, BUSY, bus.MEMRead}, 32'b0);
        runScan("after_abort", 1'b0);

        applyStimulus(1'b1, 1'b1);
        checkOutput("rst_start_flags", {28'b0, BUSY, bus.MEMRead, bus.MEMWrite, DONE}, 32'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_start_idle", {29'b0, BUSY, bus.MEMRead, bus.MEMWrite}, 32'b0);
        checkOutput("rst_start_addr", bus.ADDR, 32'd0);

        fillSorted();
        runScan("noisy_start", 1'b1);
        checkOutput("noisy_start_pass", 32'(PASS), 32'd1);
        mem[BASE[9:2] + 8'd3] = 32'd99;
        runScan("rescan", 1'b0);
        checkOutput("rescan_led3", 32'(LED[3]), 32'd0);
        checkOutput("rescan_pass", 32'(PASS), 32'd0);

        for (int t = 0; t < 6; t++) begin
            fillSorted();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) mem[BASE[9:2] + 8'(i)] = $urandom;
            end
            runScan($sformatf("random%0d", t), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
